ecc_port_responder: RTL and testbench
=====================================

Name: ecc_port_responder

Overview:
- Single-port memory responder. Accepts en/we/addr/data requests, one per clock, from an initiator such as the subsystem bench or a port arbiter.
- Applies fixed write and read latencies. Hamming(12,8) encodes write data into a 1R1W memory bank and decodes/corrects read data.
- Sits between a port interface and a bank instance in sub_system. It is the responder end of the en/we/Add/Din/Dout port protocol.

Parameters:
D_W, 8, data width (fixed 8 for Hamming(12,8))
A_W, 6, address width; depth 2**A_W
R_W, 12, stored codeword width (D_W+4)
WL, 3, write latency in cycles, range 1..8
RL, 3, read latency in cycles, range 2..8

Ports:
input_clk  in  1  clock, all logic rising-edge
input_rst_n  in  1  asynchronous active-low reset
input_en  in  1  request valid
input_we  in  1  1=write, 0=read (qualified by input_en)
input_Add  in  A_W  request address
input_Din  in  D_W  write data
final_Dout  out  D_W  read data (corrected)
dout_valid  out  1  one-cycle pulse, final_Dout holds a new read result
err_corr  out  1  with dout_valid: single-bit error corrected
err_uncorr  out  1  with dout_valid: syndrome >12, data passed raw
ram_we  out  1  bank write strobe
ram_waddr  out  A_W  bank write address
ram_wdata  out  R_W  bank write codeword
ram_re  out  1  bank read strobe
ram_raddr  out  A_W  bank read address
ram_rdata  in  R_W  bank read codeword, valid one cycle after ram_re cycle

Behaviour:
- Reset (async assert, sync release): all outputs 0; write and read pipes flushed. Pending writes are dropped and never committed; pending reads produce no dout_valid.
- Acceptance: request sampled at every rising edge with input_en=1. There is no backpressure; one request per cycle is always accepted.
- Write path:
  - Encode at acceptance.
  - Codeword bit p-1 = Hamming position p (1..12). Parity at positions 1,2,4,8. Din[0..7] map to positions 3,5,6,7,9,10,11,12. Even parity.
  - Stage through a WL-deep pipe. ram_we=1 with ram_waddr/ram_wdata during the cycle before edge acc+WL, so the bank commits at edge acc+WL.
- Read path:
  - Read accepted at edge acc. ram_re=1 with ram_raddr registered in cycle acc..acc+1.
  - ram_rdata is captured at edge acc+2, then decoded combinationally.
  - Syndrome = XOR of indices of set bits.
    - 0: no error.
    - 1..12: flip that bit, set err_corr.
    - 13..15: err_uncorr, data bits passed unmodified.
  - Result delayed so that final_Dout, dout_valid and flags update at edge acc+RL.
- Output hold: final_Dout holds its last value between pulses. err flags are 0 when dout_valid=0.
- Read-after-write forwarding:
  - Applies if, at read acceptance, a write to the same address is accepted but its commit edge is later than the read's acceptance edge.
  - The youngest such write's Din is returned at acc+RL with err_corr=err_uncorr=0. The bank read still issues.
- Writes committing at the same edge as the read's acceptance are not forwarded; the bank provides the new data.
- ram_we and ram_re may be high in the same cycle (different requests). The bank is 1R1W.
- Simultaneous read and write requests cannot occur (single port). A write followed by a read of the same address in the next cycle must forward.
- Address wrap: none; all 2**A_W addresses valid.

Test Plan:
1. Reset, write Add=5 Din=0xA5 -> ram_we pulses once, ram_waddr=5, ram_wdata=0xA27, commit at edge acc+3. Read Add=5 afterwards -> final_Dout=0xA5, dout_valid at acc+3, err_corr=0.
2. Bank model returns 0xA27^0x010 (position 5 flipped) on read -> final_Dout=0xA5, err_corr=1, err_uncorr=0.
3. Bank returns 0xA27^0x003 (positions 1,2 flipped, syndrome 3) -> miscorrection accepted, err_corr=1. Separately, force syndrome 15 -> err_uncorr=1, raw data bits out.
4. Write Add=9 Din=0x3C, read Add=9 next cycle -> final_Dout=0x3C at read acc+RL via forwarding. Two writes to 9 (0x11 then 0x22) then read -> 0x22.
5. Back-to-back reads of addresses 0..63 after a full write of Din=i -> 64 consecutive dout_valid pulses, final_Dout=i, no gaps.
6. Assert input_rst_n low mid-stream with 2 writes and 2 reads in flight -> outputs 0 immediately, no ram_we afterward, no dout_valid until new reads. Bank contents for the pending write addresses are unchanged.

Source files
------------

// File: rtl/ecc_port_responder_if.sv
// Request/response and bank-side signals of the ECC port responder.
// The slave modport is the responder. The master modport is the initiator, which also plays the bank.
interface ecc_port_responder_if #(
  parameter int D_W = 8,
  parameter int A_W = 6,
  parameter int R_W = 12
);
  logic           input_en;
  logic           input_we;
  logic [A_W-1:0] input_Add;
  logic [D_W-1:0] input_Din;
  logic [D_W-1:0] final_Dout;
  logic           dout_valid;
  logic           err_corr;
  logic           err_uncorr;
  logic           ram_we;
  logic [A_W-1:0] ram_waddr;
  logic [R_W-1:0] ram_wdata;
  logic           ram_re;
  logic [A_W-1:0] ram_raddr;
  logic [R_W-1:0] ram_rdata;

  // Handshake: a request is taken at every rising edge with input_en=1 (no backpressure,
  // no ready). dout_valid is a one-cycle pulse, and err_corr/err_uncorr are only ever
  // high together with it. ram_rdata answers the ram_re cycle one cycle later.
  modport slave (
    input  input_en, input_we, input_Add, input_Din, ram_rdata,
    output final_Dout, dout_valid, err_corr, err_uncorr,
    output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
  );

  modport master (
    output input_en, input_we, input_Add, input_Din, ram_rdata,
    input  final_Dout, dout_valid, err_corr, err_uncorr,
    input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
  );
endinterface

// File: rtl/ecc_port_responder.sv
// Single-port responder that Hamming(12,8)-protects a 1R1W bank. Writes commit at acc+WL.
// Reads return the corrected data, or forwarded in-flight write data, at acc+RL.
module ecc_port_responder #(
  parameter int D_W = 8,
  parameter int A_W = 6,
  parameter int R_W = 12,
  parameter int WL  = 3,
  parameter int RL  = 3
) (
  input  logic                 input_clk,
  input  logic                 input_rst_n,
  ecc_port_responder_if.slave  bus
);

  // Codeword bit p-1 holds Hamming position p. Parity sits at positions 1, 2, 4 and 8 (even parity).
  function automatic logic [R_W-1:0] f_encode(input logic [D_W-1:0] d);
    logic [R_W-1:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  logic           w_wr_acc;
  logic           w_rd_acc;
  logic [R_W-1:0] w_enc;

  assign w_wr_acc = bus.input_en & bus.input_we;
  assign w_rd_acc = bus.input_en & ~bus.input_we;
  assign w_enc    = f_encode(bus.input_Din);

  // Write pipe: stage k holds the write accepted k+1 edges ago; the last stage drives the bank.
  logic           r_wv [WL];
  logic [A_W-1:0] r_wa [WL];
  logic [D_W-1:0] r_wd [WL];
  logic [R_W-1:0] r_wc [WL];

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      for (int k = 0; k < WL; k++) begin
        r_wv[k] <= 1'b0;
        r_wa[k] <= '0;
        r_wd[k] <= '0;
        r_wc[k] <= '0;
      end
    end else begin
      r_wv[0] <= w_wr_acc;
      r_wa[0] <= w_wr_acc ? bus.input_Add : '0;
      r_wd[0] <= w_wr_acc ? bus.input_Din : '0;
      r_wc[0] <= w_wr_acc ? w_enc : '0;
      for (int k = 1; k < WL; k++) begin
        r_wv[k] <= r_wv[k-1];
        r_wa[k] <= r_wa[k-1];
        r_wd[k] <= r_wd[k-1];
        r_wc[k] <= r_wc[k-1];
      end
    end
  end

  assign bus.ram_we    = r_wv[WL-1];
  assign bus.ram_waddr = r_wa[WL-1];
  assign bus.ram_wdata = r_wc[WL-1];

  // The last stage commits on the read's own acceptance edge, so only stages 0..WL-2 forward.
  // The loop runs oldest to youngest, so the youngest matching write wins.
  logic           w_fwd_hit;
  logic [D_W-1:0] w_fwd_data;

  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = WL - 2; k >= 0; k--) begin
      if (r_wv[k] && (r_wa[k] == bus.input_Add)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wd[k];
      end
    end
  end

  logic           r_re;
  logic [A_W-1:0] r_ra;
  logic           r_rfh0;
  logic [D_W-1:0] r_rfd0;
  logic           r_rv1;
  logic           r_rfh1;
  logic [D_W-1:0] r_rfd1;

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      r_re   <= 1'b0;
      r_ra   <= '0;
      r_rfh0 <= 1'b0;
      r_rfd0 <= '0;
      r_rv1  <= 1'b0;
      r_rfh1 <= 1'b0;
      r_rfd1 <= '0;
    end else begin
      r_re   <= w_rd_acc;
      r_ra   <= w_rd_acc ? bus.input_Add : '0;
      r_rfh0 <= w_rd_acc & w_fwd_hit;
      r_rfd0 <= w_rd_acc ? w_fwd_data : '0;
      r_rv1  <= r_re;
      r_rfh1 <= r_rfh0;
      r_rfd1 <= r_rfd0;
    end
  end

  assign bus.ram_re    = r_re;
  assign bus.ram_raddr = r_ra;

  logic [3:0]     w_syn;
  logic           w_flip;
  logic           w_bad;
  logic [D_W-1:0] w_raw;
  logic [D_W-1:0] w_dmask;
  logic           w_res_v;
  logic [D_W-1:0] w_res_d;
  logic           w_res_c;
  logic           w_res_u;

  always_comb begin
    w_syn = '0;
    for (int p = 1; p <= R_W; p++) begin
      if (bus.ram_rdata[p-1]) w_syn = w_syn ^ 4'(p);
    end
    w_flip = (w_syn != 4'd0) && (w_syn <= 4'd12);
    w_bad  = (w_syn > 4'd12);
    w_raw  = {bus.ram_rdata[11], bus.ram_rdata[10], bus.ram_rdata[9], bus.ram_rdata[8],
              bus.ram_rdata[6], bus.ram_rdata[5], bus.ram_rdata[4], bus.ram_rdata[2]};
    // A syndrome of 1, 2, 4 or 8 names a parity bit, so the data bits need no change.
    case (w_syn)
      4'd3:    w_dmask = 8'h01;
      4'd5:    w_dmask = 8'h02;
      4'd6:    w_dmask = 8'h04;
      4'd7:    w_dmask = 8'h08;
      4'd9:    w_dmask = 8'h10;
      4'd10:   w_dmask = 8'h20;
      4'd11:   w_dmask = 8'h40;
      4'd12:   w_dmask = 8'h80;
      default: w_dmask = 8'h00;
    endcase
    w_res_v = r_rv1;
    w_res_d = r_rfh1 ? r_rfd1 : (w_raw ^ w_dmask);
    w_res_c = r_rv1 & ~r_rfh1 & w_flip;
    w_res_u = r_rv1 & ~r_rfh1 & w_bad;
  end

  // Result pipe: stage 1 loads at acc+2 and stage RL-1 is the output register (acc+RL).
  // Data moves only with a valid result, so the output holds between pulses.
  logic           r_pv [1:RL-1];
  logic           r_pc [1:RL-1];
  logic           r_pu [1:RL-1];
  logic [D_W-1:0] r_pd [1:RL-1];

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      for (int j = 1; j < RL; j++) begin
        r_pv[j] <= 1'b0;
        r_pc[j] <= 1'b0;
        r_pu[j] <= 1'b0;
        r_pd[j] <= '0;
      end
    end else begin
      r_pv[1] <= w_res_v;
      r_pc[1] <= w_res_c;
      r_pu[1] <= w_res_u;
      if (w_res_v) r_pd[1] <= w_res_d;
      for (int j = 2; j < RL; j++) begin
        r_pv[j] <= r_pv[j-1];
        r_pc[j] <= r_pc[j-1];
        r_pu[j] <= r_pu[j-1];
        if (r_pv[j-1]) r_pd[j] <= r_pd[j-1];
      end
    end
  end

  assign bus.final_Dout = r_pd[RL-1];
  assign bus.dout_valid = r_pv[RL-1];
  assign bus.err_corr   = r_pc[RL-1];
  assign bus.err_uncorr = r_pu[RL-1];

endmodule

// File: tb/tb_ecc_port_responder.sv
// Directed bench for ecc_port_responder: table of requests with hand-computed results,
// a bank model with per-address corruption masks, and a latency-checking scoreboard.
module tb_ecc_port_responder;
  localparam int D_W = 8;
  localparam int A_W = 6;
  localparam int R_W = 12;
  localparam int WL  = 3;
  localparam int RL  = 3;
  localparam int NV  = 22;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ecc_port_responder_if #(.D_W(D_W), .A_W(A_W), .R_W(R_W)) bus ();

  ecc_port_responder #(.D_W(D_W), .A_W(A_W), .R_W(R_W), .WL(WL), .RL(RL)) dut (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .bus         (bus)
  );

  logic [R_W-1:0] mem     [2**A_W] = '{default: '0};
  logic [R_W-1:0] corrupt [2**A_W];
  logic [R_W-1:0] rdata_r = '0;

  assign bus.ram_rdata = rdata_r;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_re) rdata_r <= mem[bus.ram_raddr] ^ corrupt[bus.ram_raddr];
  end

  typedef struct packed {
    int             cyc;
    logic [D_W-1:0] d;
    logic           c;
    logic           u;
  } rexp_t;

  typedef struct packed {
    int             cyc;
    logic [A_W-1:0] a;
    logic [R_W-1:0] w;
  } wexp_t;

  typedef struct {
    logic           we;
    logic [A_W-1:0] addr;
    logic [D_W-1:0] din;
    logic [R_W-1:0] cw;
    logic [D_W-1:0] ed;
    logic           ec;
    logic           eu;
    int             gap;
  } vec_t;

  rexp_t          exp_q [$];
  wexp_t          wexp_q [$];
  rexp_t          mr;
  wexp_t          mw;
  logic [D_W-1:0] last_d = '0;
  vec_t           vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Generic Hamming encoder: data fills the non-power-of-two positions in order.
  function automatic logic [R_W-1:0] tb_enc(input logic [D_W-1:0] d);
    logic [R_W-1:0] c;
    int n;
    c = '0;
    n = 0;
    for (int p = 1; p <= R_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= R_W; p++) begin
        if ((((p >> k) & 1) == 1) && (p != (1 << k))) par = par ^ c[p-1];
      end
      c[(1 << k) - 1] = par;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", {31'd0, bus.dout_valid}, 32'd0);
        end else begin
          mr = exp_q.pop_front();
          check("rd_cycle", cyc, mr.cyc);
          check("rd_data", {24'd0, bus.final_Dout}, {24'd0, mr.d});
          check("rd_err_corr", {31'd0, bus.err_corr}, {31'd0, mr.c});
          check("rd_err_uncorr", {31'd0, bus.err_uncorr}, {31'd0, mr.u});
          last_d = mr.d;
        end
      end else begin
        check("dout_hold", {24'd0, bus.final_Dout}, {24'd0, last_d});
        check("flags_idle", {30'd0, bus.err_corr, bus.err_uncorr}, 32'd0);
      end
      if (bus.ram_we) begin
        if (wexp_q.size() == 0) begin
          check("wr_unexpected", {31'd0, bus.ram_we}, 32'd0);
        end else begin
          mw = wexp_q.pop_front();
          check("wr_cycle", cyc, mw.cyc);
          check("wr_addr", {26'd0, bus.ram_waddr}, {26'd0, mw.a});
          check("wr_codeword", {20'd0, bus.ram_wdata}, {20'd0, mw.w});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.input_en  = 1'b0;
      bus.input_we  = 1'b0;
      bus.input_Add = '0;
      bus.input_Din = '0;
    end
  endtask

  task automatic issue(input logic we, input logic [A_W-1:0] a, input logic [D_W-1:0] d,
                       input logic [R_W-1:0] cw, input logic [D_W-1:0] ed,
                       input logic ec, input logic eu);
    int acc;
    @(posedge clk);
    #1;
    bus.input_en  = 1'b1;
    bus.input_we  = we;
    bus.input_Add = a;
    bus.input_Din = we ? d : '0;
    acc = cyc + 1;
    if (we) wexp_q.push_back('{cyc: acc + WL - 1, a: a, w: cw});
    else    exp_q.push_back('{cyc: acc + RL, d: ed, c: ec, u: eu});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, {24'd0, bus.final_Dout}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    check({tag, "_flags"}, {30'd0, bus.err_corr, bus.err_uncorr}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, bus.ram_we}, 32'd0);
    check({tag, "_ram_re"}, {31'd0, bus.ram_re}, 32'd0);
    check({tag, "_ram_bus"}, {bus.ram_waddr, bus.ram_raddr, bus.ram_wdata}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    logic [R_W-1:0] m50;
    logic [R_W-1:0] m51;
    bus.input_en  = 1'b0;
    bus.input_we  = 1'b0;
    bus.input_Add = '0;
    bus.input_Din = '0;
    for (int i = 0; i < 2**A_W; i++) corrupt[i] = '0;
    corrupt[40] = 12'h010;
    corrupt[41] = 12'h003;
    corrupt[42] = 12'h804;
    corrupt[43] = 12'h801;
    corrupt[9]  = 12'h010;
    corrupt[20] = 12'h010;
    corrupt[21] = 12'h010;

    //          we    addr   din    cw       ed     ec    eu    gap
    vecs[0]  = '{1'b1, 6'd5,  8'hA5, 12'hA27, 8'h00, 1'b0, 1'b0, 4};
    vecs[1]  = '{1'b0, 6'd5,  8'h00, 12'h000, 8'hA5, 1'b0, 1'b0, 2};
    vecs[2]  = '{1'b1, 6'd40, 8'hA5, 12'hA27, 8'h00, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 6'd41, 8'hA5, 12'hA27, 8'h00, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 6'd42, 8'hA5, 12'hA27, 8'h00, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 6'd43, 8'h3C, 12'h362, 8'h00, 1'b0, 1'b0, 4};
    vecs[6]  = '{1'b0, 6'd40, 8'h00, 12'h000, 8'hA5, 1'b1, 1'b0, 0};
    vecs[7]  = '{1'b0, 6'd41, 8'h00, 12'h000, 8'hA4, 1'b1, 1'b0, 0};
    vecs[8]  = '{1'b0, 6'd42, 8'h00, 12'h000, 8'h24, 1'b0, 1'b1, 0};
    vecs[9]  = '{1'b0, 6'd43, 8'h00, 12'h000, 8'hBC, 1'b0, 1'b1, 3};
    vecs[10] = '{1'b1, 6'd9,  8'h3C, 12'h362, 8'h00, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b0, 6'd9,  8'h00, 12'h000, 8'h3C, 1'b0, 1'b0, 1};
    vecs[12] = '{1'b1, 6'd9,  8'h11, 12'h186, 8'h00, 1'b0, 1'b0, 0};
    vecs[13] = '{1'b1, 6'd9,  8'h22, 12'h29B, 8'h00, 1'b0, 1'b0, 0};
    vecs[14] = '{1'b0, 6'd9,  8'h00, 12'h000, 8'h22, 1'b0, 1'b0, 4};
    vecs[15] = '{1'b0, 6'd9,  8'h00, 12'h000, 8'h22, 1'b1, 1'b0, 2};
    vecs[16] = '{1'b1, 6'd20, 8'hFF, 12'hF77, 8'h00, 1'b0, 1'b0, 2};
    vecs[17] = '{1'b0, 6'd20, 8'h00, 12'h000, 8'hFF, 1'b1, 1'b0, 0};
    vecs[18] = '{1'b1, 6'd21, 8'hFF, 12'hF77, 8'h00, 1'b0, 1'b0, 1};
    vecs[19] = '{1'b0, 6'd21, 8'h00, 12'h000, 8'hFF, 1'b0, 1'b0, 3};
    vecs[20] = '{1'b1, 6'd0,  8'h00, 12'h000, 8'h00, 1'b0, 1'b0, 3};
    vecs[21] = '{1'b0, 6'd0,  8'h00, 12'h000, 8'h00, 1'b0, 1'b0, 2};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].cw, vecs[i].ed, vecs[i].ec, vecs[i].eu);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    idle(8);
    check("table_rd_pending", exp_q.size(), 32'd0);
    check("table_wr_pending", wexp_q.size(), 32'd0);

    for (int i = 0; i < 2**A_W; i++) corrupt[i] = '0;
    for (int i = 0; i < 2**A_W; i++) issue(1'b1, A_W'(i), D_W'(i), tb_enc(D_W'(i)), '0, 1'b0, 1'b0);
    for (int i = 0; i < 2**A_W; i++) issue(1'b0, A_W'(i), '0, '0, D_W'(i), 1'b0, 1'b0);
    idle(8);
    check("sweep_rd_pending", exp_q.size(), 32'd0);

    m50 = mem[50];
    m51 = mem[51];
    issue(1'b0, 6'd10, 8'h00, 12'h000, 8'd10, 1'b0, 1'b0);
    issue(1'b1, 6'd50, 8'h99, tb_enc(8'h99), 8'h00, 1'b0, 1'b0);
    issue(1'b1, 6'd51, 8'h98, tb_enc(8'h98), 8'h00, 1'b0, 1'b0);
    issue(1'b0, 6'd11, 8'h00, 12'h000, 8'd11, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.input_en = 1'b0;
    exp_q.delete();
    wexp_q.delete();
    last_d = '0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);
    check("bank50_kept", {20'd0, mem[50]}, {20'd0, m50});
    check("bank51_kept", {20'd0, mem[51]}, {20'd0, m51});
    issue(1'b0, 6'd50, 8'h00, 12'h000, 8'd50, 1'b0, 1'b0);
    issue(1'b0, 6'd51, 8'h00, 12'h000, 8'd51, 1'b0, 1'b0);
    idle(8);
    check("final_rd_pending", exp_q.size(), 32'd0);
    check("final_wr_pending", wexp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
